// File: rtl/perm_stream_out_if.sv
// perm_stream_out_if: handshake bundle for the permutation output stage.
// Input side carries one N-entry permutation per valid/ready handshake.
// Output side carries one (job, work) pair per valid/ready handshake, plus
// status (completed-permutation count, sticky invalid-permutation flag).
// The block itself connects through modport master; the environment
// (permutation generator + consumer) connects through modport slave.
interface perm_stream_out_if #(
    parameter int N     = 8,
    parameter int W     = 3,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [N*W-1:0]   in_list;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_job;
    logic [W-1:0]     out_work;
    logic             out_eop;
    logic             out_final;
    logic [CNT_W-1:0] perm_cnt;
    logic             perm_err;

    modport master (
        input  in_valid,
        input  in_list,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_job,
        output out_work,
        output out_eop,
        output out_final,
        output perm_cnt,
        output perm_err
    );

    modport slave (
        output in_valid,
        output in_list,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_job,
        input  out_work,
        input  out_eop,
        input  out_final,
        input  perm_cnt,
        input  perm_err
    );
endinterface

// File: rtl/perm_stream_out.sv
// perm_stream_out: serialises N-entry permutations into (job, work) pairs.
// Two buffers (active + pending) let a new permutation be taken while the
// current one streams, so back-to-back permutations emit one pair per cycle.
// All outputs come straight from registers; no input reaches an output
// combinationally.
// Optional build macro PERM_STREAM_OUT_PERM_CHECK_EN: checks each accepted
// list for range and uniqueness and raises a sticky perm_err on failure.
// Without the macro perm_err is tied low and no checker is built.
module perm_stream_out #(
    parameter int N     = 8,
    parameter int W     = 3,
    parameter int CNT_W = 16
) (
    input logic                CLK,
    input logic                RST,
    perm_stream_out_if.master  bus
);

    // Buffer state
    logic [N*W-1:0]   active_q,      active_d;
    logic [N*W-1:0]   pend_q,        pend_d;
    logic             active_desc_q, active_desc_d;
    logic             pend_desc_q,   pend_desc_d;
    logic             active_v_q,    active_v_d;
    logic             pend_v_q,      pend_v_d;
    logic [W-1:0]     idx_q,         idx_d;
    logic [CNT_W-1:0] perm_cnt_q,    perm_cnt_d;

    // Handshake decode
    logic accept_s;
    logic xfer_s;
    logic last_s;
    logic eop_xfer_s;
    logic in_desc_s;

    // True when the list is exactly N-1, N-2, ..., 0 (element i == N-1-i).
    function automatic logic is_descending(input logic [N*W-1:0] lst);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (lst[i*W +: W] != W'(N - 1 - i)) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    assign accept_s   = bus.in_valid && !pend_v_q;
    assign xfer_s     = active_v_q && bus.out_ready;
    assign last_s     = (idx_q == W'(N - 1));
    assign eop_xfer_s = xfer_s && last_s;
    assign in_desc_s  = is_descending(bus.in_list);

    // Next-state for buffers, index and completed-permutation counter
    always_comb begin
        active_d      = active_q;
        active_desc_d = active_desc_q;
        active_v_d    = active_v_q;
        pend_d        = pend_q;
        pend_desc_d   = pend_desc_q;
        pend_v_d      = pend_v_q;
        idx_d         = idx_q;
        perm_cnt_d    = perm_cnt_q;

        if (eop_xfer_s) begin
            // Last pair leaves: refill active from pending, else from the
            // input in the same cycle, else go empty.
            idx_d = {W{1'b0}};
            if (perm_cnt_q != {CNT_W{1'b1}}) begin
                perm_cnt_d = perm_cnt_q + CNT_W'(1);
            end else begin
                perm_cnt_d = perm_cnt_q;
            end
            if (pend_v_q) begin
                active_d      = pend_q;
                active_desc_d = pend_desc_q;
                pend_v_d      = 1'b0;
            end else if (accept_s) begin
                active_d      = bus.in_list;
                active_desc_d = in_desc_s;
            end else begin
                active_v_d    = 1'b0;
            end
        end else begin
            if (xfer_s) begin
                idx_d = idx_q + W'(1);
            end else begin
                idx_d = idx_q;
            end
            // Accept is independent of a mid-permutation transfer
            if (accept_s) begin
                if (!active_v_q) begin
                    active_d      = bus.in_list;
                    active_desc_d = in_desc_s;
                    active_v_d    = 1'b1;
                end else begin
                    pend_d        = bus.in_list;
                    pend_desc_d   = in_desc_s;
                    pend_v_d      = 1'b1;
                end
            end else begin
                active_v_d = active_v_d;
            end
        end
    end

    // State registers with synchronous reset that drops both buffers
    always_ff @(posedge CLK) begin
        if (RST) begin
            active_q      <= '0;
            pend_q        <= '0;
            active_desc_q <= 1'b0;
            pend_desc_q   <= 1'b0;
            active_v_q    <= 1'b0;
            pend_v_q      <= 1'b0;
            idx_q         <= '0;
            perm_cnt_q    <= '0;
        end else begin
            active_q      <= active_d;
            pend_q        <= pend_d;
            active_desc_q <= active_desc_d;
            pend_desc_q   <= pend_desc_d;
            active_v_q    <= active_v_d;
            pend_v_q      <= pend_v_d;
            idx_q         <= idx_d;
            perm_cnt_q    <= perm_cnt_d;
        end
    end

    assign bus.in_ready  = !pend_v_q;
    assign bus.out_valid = active_v_q;
    assign bus.out_job   = active_q[int'(idx_q)*W +: W];
    assign bus.out_work  = idx_q;
    assign bus.out_eop   = active_v_q && last_s;
    assign bus.out_final = active_v_q && last_s && active_desc_q;
    assign bus.perm_cnt  = perm_cnt_q;

`ifdef PERM_STREAM_OUT_PERM_CHECK_EN
    logic perm_err_q, perm_err_d;
    logic in_bad_s;

    // True when every element is below N and no two elements repeat.
    function automatic logic is_valid_perm(input logic [N*W-1:0] lst);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (int'(lst[i*W +: W]) >= N) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
            for (int j = i + 1; j < N; j++) begin
                if (lst[i*W +: W] == lst[j*W +: W]) begin
                    ok = 1'b0;
                end else begin
                    ok = ok;
                end
            end
        end
        return ok;
    endfunction

    assign in_bad_s = !is_valid_perm(bus.in_list);

    // Sticky error: set by any accepted bad list, cleared only by reset
    always_comb begin
        perm_err_d = perm_err_q;
        if (accept_s && in_bad_s) begin
            perm_err_d = 1'b1;
        end else begin
            perm_err_d = perm_err_q;
        end
    end

    // Error flag register
    always_ff @(posedge CLK) begin
        if (RST) begin
            perm_err_q <= 1'b0;
        end else begin
            perm_err_q <= perm_err_d;
        end
    end

    assign bus.perm_err = perm_err_q;
`else
    assign bus.perm_err = 1'b0;
`endif

endmodule

// File: tb/tb_perm_stream_out.sv
// Scoreboard bench for perm_stream_out: stimulus tasks push expected pairs
// when a permutation is accepted; monitors pop and compare on each transfer.
// An N=8 instance covers the main behaviour; an N=5 instance covers index
// wrap below 2^W and the optional list checker.
module tb_perm_stream_out;

`ifdef PERM_STREAM_OUT_PERM_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic CLK;
    logic RST;

    perm_stream_out_if #(.N(8), .W(3), .CNT_W(16)) bus  ();
    perm_stream_out_if #(.N(5), .W(3), .CNT_W(16)) bus5 ();

    perm_stream_out #(.N(8), .W(3), .CNT_W(16)) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    perm_stream_out #(.N(5), .W(3), .CNT_W(16)) u_dut5 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus5)
    );

    int n_vec;
    int n_err;

    // expected entry: {job[2:0], work[2:0], eop, final}
    logic [7:0] exp_q  [$];
    logic [7:0] exp5_q [$];

    int         xfer_cnt;
    int         run_len;
    int         max_run;
    logic       saw_nr;
    logic       stall_en;
    logic [31:0] stall_pat;
    int         stall_ph;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic fail_to(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: got no response within budget, expected one", nm);
    endtask

    // Offer a permutation to the N=8 instance; push its pairs once accepted.
    task automatic send8(input logic [23:0] lst, input logic desc);
        int   k;
        logic acc;
        bus.in_list  = lst;
        bus.in_valid = 1'b1;
        acc = 1'b0;
        k = 0;
        while (!acc && k < 200) begin
            @(negedge CLK);
            k++;
            if (bus.in_ready) acc = 1'b1;
        end
        if (!acc) begin
            fail_to("accept8_timeout");
        end else begin
            for (int i = 0; i < 8; i++) begin
                exp_q.push_back({lst[i*3 +: 3], 3'(i), (i == 7), (i == 7) && desc});
            end
        end
        @(posedge CLK);
        #1;
    endtask

    // Offer a permutation to the N=5 instance, then drop in_valid.
    task automatic send5(input logic [14:0] lst);
        int   k;
        logic acc;
        bus5.in_list  = lst;
        bus5.in_valid = 1'b1;
        acc = 1'b0;
        k = 0;
        while (!acc && k < 200) begin
            @(negedge CLK);
            k++;
            if (bus5.in_ready) acc = 1'b1;
        end
        if (!acc) begin
            fail_to("accept5_timeout");
        end else begin
            for (int i = 0; i < 5; i++) begin
                exp5_q.push_back({lst[i*3 +: 3], 3'(i), (i == 4), 1'b0});
            end
        end
        @(posedge CLK);
        #1;
        bus5.in_valid = 1'b0;
    endtask

    task automatic wait_idle8(input int budget);
        int k;
        k = 0;
        @(negedge CLK);
        while ((bus.out_valid || exp_q.size() != 0) && k < budget) begin
            @(negedge CLK);
            k++;
        end
        if (k >= budget) fail_to("idle8_timeout");
    endtask

    task automatic wait_idle5(input int budget);
        int k;
        k = 0;
        @(negedge CLK);
        while ((bus5.out_valid || exp5_q.size() != 0) && k < budget) begin
            @(negedge CLK);
            k++;
        end
        if (k >= budget) fail_to("idle5_timeout");
    endtask

    // Monitor for N=8: pair scoreboard, stall stability, run length
    initial begin
        logic [7:0] cur;
        logic [7:0] snap;
        logic [7:0] e;
        logic       hold;
        hold = 1'b0;
        snap = '0;
        forever begin
            @(negedge CLK);
            cur = {bus.out_job, bus.out_work, bus.out_eop, bus.out_final};
            if (RST) begin
                hold    = 1'b0;
                run_len = 0;
            end else begin
                if (bus.out_valid) begin
                    run_len++;
                    if (run_len > max_run) max_run = run_len;
                end else begin
                    run_len = 0;
                end
                if (!bus.in_ready) saw_nr = 1'b1;
                if (hold) chk("stall_hold", 32'(cur), 32'(snap));
                if (bus.out_valid && bus.out_ready) begin
                    hold = 1'b0;
                    xfer_cnt++;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL pair8_unexpected: got %0h, expected no pair", cur);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pair8", 32'(cur), 32'(e));
                    end
                end else if (bus.out_valid) begin
                    hold = 1'b1;
                    snap = cur;
                end else begin
                    hold = 1'b0;
                end
            end
        end
    end

    // Monitor for N=5: pair scoreboard
    initial begin
        logic [7:0] cur;
        logic [7:0] e;
        forever begin
            @(negedge CLK);
            cur = {bus5.out_job, bus5.out_work, bus5.out_eop, bus5.out_final};
            if (!RST && bus5.out_valid && bus5.out_ready) begin
                if (exp5_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL pair5_unexpected: got %0h, expected no pair", cur);
                end else begin
                    e = exp5_q.pop_front();
                    chk("pair5", 32'(cur), 32'(e));
                end
            end
        end
    end

    // Deterministic out_ready stall pattern when enabled
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (stall_en) begin
                bus.out_ready = stall_pat[stall_ph];
                stall_ph = (stall_ph + 1) % 32;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   k;
        int   base;
        logic found;
        n_vec     = 0;
        n_err     = 0;
        xfer_cnt  = 0;
        run_len   = 0;
        max_run   = 0;
        saw_nr    = 1'b0;
        stall_en  = 1'b0;
        stall_ph  = 0;
        stall_pat = 32'hB2D5_9A63;
        RST            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_list    = '0;
        bus.out_ready  = 1'b1;
        bus5.in_valid  = 1'b0;
        bus5.in_list   = '0;
        bus5.out_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Reset state
        @(negedge CLK);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_job",   32'(bus.out_job),   32'd0);
        chk("rst_out_work",  32'(bus.out_work),  32'd0);
        chk("rst_out_eop",   32'(bus.out_eop),   32'd0);
        chk("rst_out_final", 32'(bus.out_final), 32'd0);
        chk("rst_perm_cnt",  32'(bus.perm_cnt),  32'd0);
        chk("rst_perm_err",  32'(bus.perm_err),  32'd0);
        @(posedge CLK);
        #1;

        // Single ascending permutation, consumer always ready
        saw_nr  = 1'b0;
        max_run = 0;
        send8(24'o76543210, 1'b0);
        bus.in_valid = 1'b0;
        wait_idle8(100);
        chk("t1_perm_cnt", 32'(bus.perm_cnt), 32'd1);
        chk("t1_in_ready_high", 32'(saw_nr), 32'd0);
        chk("t1_run", 32'(max_run), 32'd8);
        @(posedge CLK);
        #1;

        // Three back-to-back permutations: 24 contiguous valid cycles
        saw_nr  = 1'b0;
        max_run = 0;
        send8(24'o35172064, 1'b0);
        send8(24'o12345670, 1'b0);
        send8(24'o64201357, 1'b0);
        bus.in_valid = 1'b0;
        wait_idle8(200);
        chk("t2_run", 32'(max_run), 32'd24);
        chk("t2_in_ready_drop", 32'(saw_nr), 32'd1);
        chk("t2_perm_cnt", 32'(bus.perm_cnt), 32'd4);
        @(posedge CLK);
        #1;

        // Descending permutation: final only on (job 0, work 7)
        send8(24'o01234567, 1'b1);
        bus.in_valid = 1'b0;
        wait_idle8(100);
        chk("t3_perm_cnt", 32'(bus.perm_cnt), 32'd5);
        @(posedge CLK);
        #1;

        // Stalled consumer with two queued; third held off until first ends
        bus.out_ready = 1'b0;
        send8(24'o35172064, 1'b0);
        send8(24'o12345670, 1'b0);
        base = xfer_cnt;
        stall_en = 1'b1;
        send8(24'o76543210, 1'b0);
        bus.in_valid = 1'b0;
        chk("t4_holdoff", 32'(((xfer_cnt - base) >= 8)), 32'd1);
        wait_idle8(400);
        stall_en = 1'b0;
        bus.out_ready = 1'b1;
        chk("t4_perm_cnt", 32'(bus.perm_cnt), 32'd8);
        @(posedge CLK);
        #1;

        // Reset mid-stream at idx 4 with pending full
        send8(24'o35172064, 1'b0);
        send8(24'o64201357, 1'b0);
        bus.in_valid = 1'b0;
        found = 1'b0;
        k = 0;
        while (!found && k < 50) begin
            @(negedge CLK);
            k++;
            if (bus.out_valid && bus.out_work == 3'd3) found = 1'b1;
        end
        if (!found) fail_to("t5_idx3_timeout");
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        exp_q.delete();
        @(negedge CLK);
        chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_in_ready",  32'(bus.in_ready),  32'd1);
        chk("t5_perm_cnt",  32'(bus.perm_cnt),  32'd0);
        chk("t5_out_work",  32'(bus.out_work),  32'd0);
        chk("t5_out_eop",   32'(bus.out_eop),   32'd0);
        @(posedge CLK);
        #1;
        send8(24'o12345670, 1'b0);
        bus.in_valid = 1'b0;
        wait_idle8(100);
        chk("t5_perm_cnt_after", 32'(bus.perm_cnt), 32'd1);
        @(posedge CLK);
        #1;

        // N=5: list 0,1,1,3,4 then a valid list; work wraps 4 -> 0
        send5(15'o43110);
        @(negedge CLK);
        chk("t6_perm_err_early", 32'(bus5.perm_err), 32'(EXP_ERR));
        wait_idle5(100);
        @(posedge CLK);
        #1;
        send5(15'o43210);
        wait_idle5(100);
        chk("t6_perm_err_sticky", 32'(bus5.perm_err), 32'(EXP_ERR));
        chk("t6_perm_cnt", 32'(bus5.perm_cnt), 32'd2);
        chk("t6_perm_err_n8", 32'(bus.perm_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
